ras_ckpt: RTL

- Parametrised return-address stack (RAS) for the frontend branch predictor, sized by RASDepth.
- Successor to the fixed shift-register RAS: implemented as a circular buffer with a wrap-around top pointer and an occupancy counter.
- Adds overflow/underflow reporting and a checkpoint/restore port so the frontend can rewind speculative push/pop on mispredict.
- Sits between frontend call/return decode and next-PC selection.

---
 rtl/ras_ckpt.sv | 89 ++++++++
 1 files changed

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular-buffer return-address stack with overflow/underflow flags and checkpoint restore
module ras_ckpt #(
  parameter int RASDepth = 2,
  parameter int VLEN = 32,
  localparam int PtrW = $clog2(RASDepth),
  localparam int CntW = $clog2(RASDepth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  input  logic            restore_i,
  input  logic [PtrW-1:0] restore_ptr_i,
  input  logic [CntW-1:0] restore_cnt_i,
  output logic [VLEN-1:0] data_o,
  output logic            valid_o,
  output logic [PtrW-1:0] ckpt_ptr_o,
  output logic [CntW-1:0] ckpt_cnt_o,
  output logic            overflow_o,
  output logic            underflow_o
);
  logic [VLEN-1:0] mem [RASDepth];
  logic [PtrW-1:0] tp, tp_inc, tp_dec, tp_n, wa;
  logic [CntW-1:0] cnt, cnt_n;
  logic            we, full, empty, op;

  assign tp_inc = (tp == PtrW'(RASDepth - 1)) ? '0 : tp + 1'b1;
  assign tp_dec = (tp == '0) ? PtrW'(RASDepth - 1) : tp - 1'b1;
  assign full   = cnt == CntW'(RASDepth);
  assign empty  = cnt == '0;
  assign op     = !flush_bp_i && !restore_i;

  assign data_o      = mem[tp];
  assign valid_o     = !empty;
  assign ckpt_ptr_o  = tp;
  assign ckpt_cnt_o  = cnt;
  assign overflow_o  = op && push_i && !pop_i && full;
  assign underflow_o = op && pop_i && !push_i && empty;

  // next pointer/count and write request, flush over restore over push/pop
  always_comb begin
    tp_n  = tp;
    cnt_n = cnt;
    we    = 1'b0;
    wa    = tp_inc;
    if (flush_bp_i) begin
      tp_n  = '0;
      cnt_n = '0;
    end else if (restore_i) begin
      tp_n  = restore_ptr_i;
      cnt_n = restore_cnt_i;
    end else if (push_i && pop_i && !empty) begin
      we = 1'b1;
      wa = tp;
    end else if (push_i) begin
      we    = 1'b1;
      tp_n  = tp_inc;
      cnt_n = full ? cnt : cnt + 1'b1;
    end else if (pop_i && !empty) begin
      tp_n  = tp_dec;
      cnt_n = cnt - 1'b1;
    end
  end

  // top pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tp  <= '0;
      cnt <= '0;
    end else begin
      tp  <= tp_n;
      cnt <= cnt_n;
    end
  end

  // return-address storage, cleared on reset so data_o reads zero afterwards
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RASDepth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= data_i;
    end
  end

  a_restore_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    restore_i |-> restore_cnt_i <= CntW'(RASDepth));
endmodule
